// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-write/two-read register file with per-register pending scoreboard
// Optional REGFILE_BYPASS_EN forwards same-cycle writes (and their pending clears) to the read ports.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    input  logic            we0,
    input  logic [AW-1:0]   rd0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [AW-1:0]   rd1,
    input  logic [XLEN-1:0] wd1,
    input  logic            iss_v,
    input  logic [AW-1:0]   iss_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            any_busy
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            pending[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                // port 1 wins a same-register collision
                if (we1 && rd1 == AW'(i)) begin
                    regs[i] <= wd1;
                end else if (we0 && rd0 == AW'(i)) begin
                    regs[i] <= wd0;
                end
                // an issue in the same cycle as a completing write leaves the bit set
                if (iss_v && iss_rd == AW'(i)) begin
                    pending[i] <= 1'b1;
                end else if ((we0 && rd0 == AW'(i)) || (we1 && rd1 == AW'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    assign any_busy = |pending;

`ifdef REGFILE_BYPASS_EN
    logic h0_1, h1_1, h0_2, h1_2;

    assign h0_1 = RST_N && we0 && (rd0 == rs1) && (rs1 != '0);
    assign h1_1 = RST_N && we1 && (rd1 == rs1) && (rs1 != '0);
    assign h0_2 = RST_N && we0 && (rd0 == rs2) && (rs2 != '0);
    assign h1_2 = RST_N && we1 && (rd1 == rs2) && (rs2 != '0);

    always_comb begin
        rs1_value = regs[rs1];
        rs1_busy  = pending[rs1];
        if (h1_1) begin
            rs1_value = wd1;
        end else if (h0_1) begin
            rs1_value = wd0;
        end
        if (h0_1 || h1_1) begin
            rs1_busy = iss_v && (iss_rd == rs1);
        end
    end

    always_comb begin
        rs2_value = regs[rs2];
        rs2_busy  = pending[rs2];
        if (h1_2) begin
            rs2_value = wd1;
        end else if (h0_2) begin
            rs2_value = wd0;
        end
        if (h0_2 || h1_2) begin
            rs2_busy = iss_v && (iss_rd == rs2);
        end
    end
`else
    assign rs1_value = regs[rs1];
    assign rs2_value = regs[rs2];
    assign rs1_busy  = pending[rs1];
    assign rs2_busy  = pending[rs2];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized scoreboard bench for regfile_mp against an array model
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   rs1, rs2, rd0, rd1, iss_rd;
    logic [XLEN-1:0] wd0, wd1;
    logic            we0, we1, iss_v;
    logic [XLEN-1:0] rs1_value, rs2_value;
    logic            rs1_busy, rs2_busy, any_busy;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG)) dut (
        .CLK(clk), .RST_N(rst_n),
        .rs1(rs1), .rs2(rs2), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .we0(we0), .rd0(rd0), .wd0(wd0),
        .we1(we1), .rd1(rd1), .wd1(wd1),
        .iss_v(iss_v), .iss_rd(iss_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .any_busy(any_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [XLEN-1:0] v1;
        logic [XLEN-1:0] v2;
        logic            b1;
        logic            b2;
        logic            ab;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    logic [XLEN-1:0] model_mem [NREG];
    bit              model_pend [NREG];

    function automatic void model_clear();
        for (int i = 0; i < NREG; i++) begin
            model_mem[i]  = '0;
            model_pend[i] = 1'b0;
        end
    endfunction

    function automatic logic [XLEN-1:0] model_val(input logic [AW-1:0] rs);
        logic [XLEN-1:0] v;
        v = model_mem[rs];
`ifdef REGFILE_BYPASS_EN
        if (rs != 0 && we0 && rd0 == rs) v = wd0;
        if (rs != 0 && we1 && rd1 == rs) v = wd1;
`endif
        return v;
    endfunction

    function automatic logic model_busy(input logic [AW-1:0] rs);
        logic b;
        b = model_pend[rs];
`ifdef REGFILE_BYPASS_EN
        if (rs != 0 && ((we0 && rd0 == rs) || (we1 && rd1 == rs)))
            b = iss_v && iss_rd == rs;
`endif
        return b;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e = '0;
        if (rst_n) begin
            e.v1 = model_val(rs1);
            e.v2 = model_val(rs2);
            e.b1 = model_busy(rs1);
            e.b2 = model_busy(rs2);
            for (int i = 0; i < NREG; i++) e.ab = e.ab | model_pend[i];
        end
        return e;
    endfunction

    function automatic void model_edge();
        if (!rst_n) return;
        if (we0 && rd0 != 0) model_mem[rd0] = wd0;
        if (we1 && rd1 != 0) model_mem[rd1] = wd1;
        if (we0 && rd0 != 0) model_pend[rd0] = 1'b0;
        if (we1 && rd1 != 0) model_pend[rd1] = 1'b0;
        if (iss_v && iss_rd != 0) model_pend[iss_rd] = 1'b1;
    endfunction

    // Called one time unit after a rising edge with inputs already set for this cycle.
    task automatic cyc(input string nm, input bit rst_mid = 1'b0);
        if (rst_mid) begin
            #2;
            rst_n = 1'b0;
            model_clear();
        end
        exp_q.push_back(model_expect());
        name_q.push_back(nm);
        @(posedge clk);
        model_edge();
        #1;
        we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
    endtask

    task automatic chk(input string nm, input string fld, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "rs1_value", rs1_value, e.v1);
            chk(nm, "rs2_value", rs2_value, e.v2);
            chk(nm, "rs1_busy", XLEN'(rs1_busy), XLEN'(e.b1));
            chk(nm, "rs2_busy", XLEN'(rs2_busy), XLEN'(e.b2));
            chk(nm, "any_busy", XLEN'(any_busy), XLEN'(e.ab));
        end
    end

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; rd0 = '0; rd1 = '0; iss_rd = '0;
        wd0 = '0; wd1 = '0; we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        rs1 = 5'd7; rs2 = 5'd31;
        cyc("in_reset");
        rst_n = 1'b1;

        for (int a = 0; a < NREG; a++) begin
            rs1 = AW'(a); rs2 = AW'(NREG - 1 - a);
            cyc("reset_read_all");
        end

        we0 = 1'b1; rd0 = 5'd5; wd0 = 32'hDEADBEEF; rs1 = 5'd5;
        cyc("w5_same_cycle");
        rs1 = 5'd5;
        cyc("w5_read");
        we0 = 1'b1; rd0 = 5'd0; wd0 = 32'h1234; rs2 = 5'd0;
        cyc("w0_attempt");
        rs2 = 5'd0;
        cyc("r0_zero");

        we0 = 1'b1; rd0 = 5'd7; wd0 = 32'h11; we1 = 1'b1; rd1 = 5'd7; wd1 = 32'h22;
        cyc("dual_w7");
        rs1 = 5'd7; rs2 = 5'd7;
        cyc("dual_r7");

        iss_v = 1'b1; iss_rd = 5'd3; rs1 = 5'd3;
        cyc("iss3");
        cyc("iss3_busy");
        we1 = 1'b1; rd1 = 5'd3; wd1 = 32'h33; iss_v = 1'b1; iss_rd = 5'd3;
        cyc("iss3_set_clr");
        iss_v = 1'b1; iss_rd = 5'd3;
        cyc("iss3_reissue");
        cyc("iss3_still");
        we0 = 1'b1; rd0 = 5'd3; wd0 = 32'h44;
        cyc("iss3_write");
        cyc("iss3_clear");

        we0 = 1'b1; rd0 = 5'd9; wd0 = 32'h55;
        cyc("w9_old");
        we0 = 1'b1; rd0 = 5'd9; wd0 = 32'hA5; rs1 = 5'd9;
        cyc("w9_bypass");
        cyc("w9_after");

        for (int r = 1; r <= 4; r++) begin
            we0 = 1'b1; rd0 = AW'(r); wd0 = 32'hC0DE0000 + r;
            iss_v = 1'b1; iss_rd = AW'(r); rs1 = AW'(r); rs2 = AW'(r);
            cyc("fill_1to4");
        end
        rs1 = 5'd2; rs2 = 5'd4;
        cyc("fill_check");
        rs1 = 5'd1; rs2 = 5'd3;
        cyc("mid_reset", 1'b1);
        we0 = 1'b1; rd0 = 5'd1; wd0 = 32'hBAD0BAD0; iss_v = 1'b1; iss_rd = 5'd1;
        cyc("reset_write");
        rst_n = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
        cyc("post_reset");

        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom); iss_v = 1'($urandom);
            rd0 = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rd1 = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            iss_rd = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rs1 = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rs2 = ($urandom % 2) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            cyc("random");
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
